rom_scan_ram: RTL and testbench

//  Parametrised successor to the lab 8x4 lookup memory: a DEPTH=2**AW x DW

---
 rtl/rom_scan_ram.sv | 114 +++++++++++
 tb/tb_rom_scan_ram.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_scan_ram.sv
// rom_scan_ram: DEPTH = 2**AW entry x DW bit synchronous RAM.
// Reset preloads mem[i] = (i*INIT_STEP) mod 2**DW. After reset it accepts writes.
// It has a registered random read port and a scan sequencer that streams
// addresses 0..DEPTH-1, one entry per cycle.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   we, waddr, wdata      write port (legal in every state)
//   re, raddr             random read request (honoured only while idle)
//   scan_start            start a full-memory scan (honoured only while idle)
//   rdata, rdaddr, rvalid registered read data, its address, valid strobe
//   scan_busy, scan_done  scan in progress / one-cycle last-word marker
module rom_scan_ram #(
    parameter int unsigned AW        = 3,
    parameter int unsigned DW        = 4,
    parameter int unsigned INIT_STEP = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    input  logic          scan_start,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] rdaddr,
    output logic          rvalid,
    output logic          scan_busy,
    output logic          scan_done
);

    localparam int unsigned DEPTH = 2 ** AW;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [DW-1:0] mem [DEPTH];
    logic [1:0]    state;
    logic [AW-1:0] ptr;

    // Read issue decode: the scan owns the read port while active.
    logic          rd_issue;
    logic [AW-1:0] rd_addr;

    always_comb begin
        rd_issue = 1'b0;
        rd_addr  = raddr;
        unique case (state)
            ST_IDLE: rd_issue = re;
            ST_SCAN: begin
                rd_issue = 1'b1;
                rd_addr  = ptr;
            end
            default: rd_issue = 1'b0;
        endcase
    end

    // Memory array. The read samples the pre-write contents, so a same-address
    // read/write returns the old data (read-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= DW'(i * INIT_STEP);
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rdaddr <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_issue;
            if (rd_issue) begin
                rdata  <= mem[rd_addr];
                rdaddr <= rd_addr;
            end
        end
    end

    // Scan sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (scan_start) begin
                        state <= ST_SCAN;
                        ptr   <= '0;
                    end
                end
                ST_SCAN: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == AW'(DEPTH - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign scan_busy = (state == ST_SCAN);
    assign scan_done = (state == ST_DONE);

endmodule

// File: tb/tb_rom_scan_ram.sv
// Bench for rom_scan_ram: directed steps followed by random traffic, all
// checked against a behavioural model of the memory and scan.
module tb_rom_scan_ram;

    localparam int DEPTH = 8;
    localparam int STEP  = 2;

    logic       clk;
    logic       rst;
    logic       we;
    logic [2:0] waddr;
    logic [3:0] wdata;
    logic       re;
    logic [2:0] raddr;
    logic       scan_start;
    logic [3:0] rdata;
    logic [2:0] rdaddr;
    logic       rvalid;
    logic       scan_busy;
    logic       scan_done;

    // Second instance with a different preload step, only ever scanned.
    logic       s3_start;
    logic [3:0] rdata3;
    logic [2:0] rdaddr3;
    logic       rvalid3;
    logic       busy3;
    logic       done3;

    rom_scan_ram #(.AW(3), .DW(4), .INIT_STEP(2)) u_dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .scan_start(scan_start),
        .rdata(rdata), .rdaddr(rdaddr), .rvalid(rvalid),
        .scan_busy(scan_busy), .scan_done(scan_done)
    );

    rom_scan_ram #(.AW(3), .DW(4), .INIT_STEP(3)) u_dut3 (
        .clk(clk), .rst(rst), .we(1'b0), .waddr(3'd0), .wdata(4'd0),
        .re(1'b0), .raddr(3'd0), .scan_start(s3_start),
        .rdata(rdata3), .rdaddr(rdaddr3), .rvalid(rvalid3),
        .scan_busy(busy3), .scan_done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    int         mdl_mem [DEPTH];
    int         scan_idx = -1;  // next address the scan will read, -1 when not scanning
    bit         mdl_done = 1'b0;
    bit         e_valid  = 1'b0;
    logic [3:0] e_data   = '0;
    logic [2:0] e_addr   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, check outputs 1 time unit later.
    task automatic step(input bit r, input bit w, input logic [2:0] wa, input logic [3:0] wd,
                        input bit rr, input logic [2:0] ra, input bit st);
        int a;
        bit iss;
        rst = r; we = w; waddr = wa; wdata = wd; re = rr; raddr = ra; scan_start = st;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) mdl_mem[i] = (i * STEP) % 16;
            e_valid = 0; e_data = '0; e_addr = '0; scan_idx = -1; mdl_done = 0;
        end else begin
            iss = 0;
            a   = 0;
            if (scan_idx >= 0) begin
                iss = 1;
                a   = scan_idx;
                scan_idx++;
                if (scan_idx == DEPTH) begin
                    scan_idx = -1;
                    mdl_done = 1;
                end
            end else if (mdl_done) begin
                mdl_done = 0;
            end else begin
                if (rr) begin
                    iss = 1;
                    a   = int'(ra);
                end
                if (st) scan_idx = 0;
            end
            e_valid = iss;
            if (iss) begin
                e_data = 4'(mdl_mem[a]);
                e_addr = 3'(a);
            end
            if (w) mdl_mem[wa] = int'(wd);
        end
        #1;
        chk("rvalid", rvalid, e_valid);
        chk("rdata", rdata, e_data);
        chk("rdaddr", rdaddr, e_addr);
        chk("scan_busy", scan_busy, scan_idx >= 0);
        chk("scan_done", scan_done, mdl_done);
    endtask

    task automatic idle();
        step(0, 0, 3'd0, 4'd0, 0, 3'd0, 0);
    endtask

    int pat2 [DEPTH] = '{0, 2, 4, 6, 8, 10, 12, 14};
    int pat3 [DEPTH] = '{0, 3, 6, 9, 12, 15, 2, 5};

    initial begin
        int busy_cnt;
        int vcnt;
        int got6;
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; re = 1'b0; raddr = '0;
        scan_start = 1'b0; s3_start = 1'b0;
        @(negedge clk);

        // Reset state.
        step(1, 0, 3'd0, 4'd0, 0, 3'd0, 0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_busy", scan_busy, 1'b0);

        // Scan of the preload pattern on both instances.
        s3_start = 1'b1;
        step(0, 0, 3'd0, 4'd0, 0, 3'd0, 1);
        s3_start = 1'b0;
        busy_cnt = scan_busy ? 1 : 0;
        for (int i = 1; i <= DEPTH; i++) begin
            idle();
            if (scan_busy) busy_cnt++;
            chk("t1_valid", rvalid, 1'b1);
            chk("t1_addr", rdaddr, i - 1);
            chk("t1_data", rdata, pat2[i-1]);
            chk("t1_done", scan_done, i == DEPTH);
            chk("t6_valid", rvalid3, 1'b1);
            chk("t6_addr", rdaddr3, i - 1);
            chk("t6_data", rdata3, pat3[i-1]);
            chk("t6_done", done3, i == DEPTH);
        end
        chk("t1_busy_cycles", busy_cnt, DEPTH);
        idle();
        chk("t1_after_done_valid", rvalid, 1'b0);

        // Write then random read.
        step(0, 1, 3'd5, 4'hF, 0, 3'd0, 0);
        step(0, 0, 3'd0, 4'd0, 1, 3'd5, 0);
        chk("t2_valid", rvalid, 1'b1);
        chk("t2_data", rdata, 4'hF);
        chk("t2_addr", rdaddr, 3'd5);
        idle();
        chk("t2_hold_valid", rvalid, 1'b0);
        chk("t2_hold_data", rdata, 4'hF);

        // Read-during-write is read-first.
        step(0, 1, 3'd3, 4'h9, 1, 3'd3, 0);
        chk("t3_old", rdata, 4'h6);
        step(0, 0, 3'd0, 4'd0, 1, 3'd3, 0);
        chk("t3_new", rdata, 4'h9);

        // Scan with competing re, a late scan_start and a write ahead of the scan.
        step(0, 0, 3'd0, 4'd0, 0, 3'd0, 1);
        vcnt = 0;
        got6 = -1;
        for (int c = 1; c <= DEPTH + 1; c++) begin
            step(0, c == 2, 3'd6, 4'h7, 1, 3'($urandom_range(0, 7)), c == 3);
            if (rvalid) vcnt++;
            if (rvalid && rdaddr == 3'd6) got6 = int'(rdata);
        end
        chk("t4_valid_count", vcnt, DEPTH);
        chk("t4_scan_sees_write", got6, 7);
        idle();
        chk("t4_no_restart", scan_busy, 1'b0);

        // Reset mid-scan.
        step(0, 1, 3'd0, 4'hF, 0, 3'd0, 0);
        step(0, 0, 3'd0, 4'd0, 0, 3'd0, 1);
        for (int c = 1; c <= 3; c++) idle();
        step(1, 0, 3'd0, 4'd0, 0, 3'd0, 0);
        chk("t5_valid", rvalid, 1'b0);
        chk("t5_busy", scan_busy, 1'b0);
        chk("t5_done", scan_done, 1'b0);
        step(0, 0, 3'd0, 4'd0, 0, 3'd0, 1);
        for (int i = 1; i <= DEPTH; i++) begin
            idle();
            chk("t5_rescan_addr", rdaddr, i - 1);
            chk("t5_rescan_data", rdata, pat2[i-1]);
        end
        idle();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 59) == 0, 1'($urandom), 3'($urandom), 4'($urandom),
                 1'($urandom), 3'($urandom), $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
